// File: rtl/mem_port_bridge_if.sv
// Bundle of core request/response and SRAM macro port signals for mem_port_bridge.
// The bridge uses the slave modport; the core/LSU side and the SRAM side use the master modport.
interface mem_port_bridge_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [31:0]           req_addr_i;
  logic [1:0]            req_size_i;
  logic                  req_unsigned_i;
  logic [31:0]           req_wdata_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [31:0]           rsp_rdata_o;
  logic                  rsp_err_o;

  logic                  mem_csb_o;
  logic                  mem_web_o;
  logic [NUM_WMASKS-1:0] mem_wmask_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_din_o;
  logic [DATA_WIDTH-1:0] mem_dout_i;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
    input  rsp_ready_i, mem_dout_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output mem_csb_o, mem_web_o, mem_wmask_o, mem_addr_o, mem_din_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
    output rsp_ready_i, mem_dout_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  mem_csb_o, mem_web_o, mem_wmask_o, mem_addr_o, mem_din_o
  );
endinterface

// File: rtl/mem_port_bridge.sv
// Load/store request adapter onto one port of the RW SRAM macro (byte lanes, wmask, load alignment).
// Optional macro MEM_BRIDGE_MISALIGN_ERR_EN: misaligned requests return rsp_err_o instead of being aligned.
module mem_port_bridge #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  mem_port_bridge_if.slave bus
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_WAIT = 2'b01,
    RESP    = 2'b10
  } state_e;

  state_e                state_q;
  state_e                state_d;
  logic [1:0]            off_q;
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  logic [1:0]            off;
  logic                  rsp_done;
  logic                  accept;
  logic                  skip_mem;
  logic                  issue;
  logic                  unused_addr_bits;

  logic                  csb;
  logic                  web;
  logic [NUM_WMASKS-1:0] wmask;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;

  assign off              = bus.req_addr_i[1:0];
  assign unused_addr_bits = ^bus.req_addr_i[31:ADDR_WIDTH+2];

  // Ready looks through to rsp_ready_i so a response can retire and a new
  // request be accepted on the same edge.
  assign rsp_done        = (state_q == RESP) && bus.rsp_ready_i;
  assign bus.req_ready_o = reset_i && ((state_q == IDLE) || rsp_done);
  assign accept          = bus.req_valid_i && bus.req_ready_o;

`ifdef MEM_BRIDGE_MISALIGN_ERR_EN
  assign skip_mem = ((bus.req_size_i == SIZE_HALF) && off[0]) ||
                    (bus.req_size_i[1] && (off != 2'b00));
`else
  assign skip_mem = 1'b0;
`endif

  assign issue = accept && !skip_mem;

  // SRAM port drive: idle values unless a request is being issued this cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    csb   = 1'b1;
    web   = 1'b1;
    wmask = '0;
    addr  = '0;
    din   = '0;
    if (issue) begin
      csb  = 1'b0;
      web  = !bus.req_we_i;
      addr = bus.req_addr_i[ADDR_WIDTH+1:2];
      if (bus.req_we_i) begin
        unique case (bus.req_size_i)
          SIZE_BYTE: begin
            din   = {4{bus.req_wdata_i[7:0]}};
            wmask = 4'b0001 << off;
          end
          SIZE_HALF: begin
            din   = {2{bus.req_wdata_i[15:0]}};
            wmask = 4'b0011 << {off[1], 1'b0};
          end
          default: begin
            din   = bus.req_wdata_i;
            wmask = 4'b1111;
          end
        endcase
      end
    end
  end

  assign bus.mem_csb_o   = csb;
  assign bus.mem_web_o   = web;
  assign bus.mem_wmask_o = wmask;
  assign bus.mem_addr_o  = addr;
  assign bus.mem_din_o   = din;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          state_d = (bus.req_we_i || skip_mem) ? RESP : RD_WAIT;
        end else if (rsp_done) begin
          state_d = IDLE;
        end
      end
      RD_WAIT: state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Shift the addressed lane down, truncate to size, then extend.
  function automatic logic [31:0] align_load(input logic [31:0] word,
                                             input logic [1:0]  offset,
                                             input logic [1:0]  size,
                                             input logic        zext);
    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] result;
    unique case (size)
      SIZE_BYTE: shamt = {offset, 3'b000};
      SIZE_HALF: shamt = {offset[1], 4'b0000};
      default:   shamt = 5'd0;
    endcase
    shifted = word >> shamt;
    unique case (size)
      SIZE_BYTE: result = zext ? {24'd0, shifted[7:0]}
                               : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_HALF: result = zext ? {16'd0, shifted[15:0]}
                               : {{16{shifted[15]}}, shifted[15:0]};
      default:   result = shifted;
    endcase
    return result;
  endfunction

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      off_q       <= 2'b00;
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= (state_d == RESP);
      if (accept) begin
        rsp_err_q <= skip_mem;
        if (!bus.req_we_i && !skip_mem) begin
          off_q      <= off;
          size_q     <= bus.req_size_i;
          unsigned_q <= bus.req_unsigned_i;
        end else begin
          rsp_rdata_q <= '0;
        end
      end else if (state_q == RD_WAIT) begin
        rsp_rdata_q <= align_load(bus.mem_dout_i, off_q, size_q, unsigned_q);
      end else if (rsp_done) begin
        rsp_err_q <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_mem_port_bridge.sv
// Scoreboard bench for mem_port_bridge: byte-array reference model, SRAM macro model,
// directed scenarios followed by randomized load/store traffic.
module tb_mem_port_bridge;

  localparam int AW = 9;

  logic clk = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk = ~clk;

  mem_port_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_WMASKS(4)) bus ();

  mem_port_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_WMASKS(4)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // SRAM macro model: registered read, byte-masked write, active-low controls.
  logic [31:0] sram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (!bus.mem_csb_o) begin
      if (!bus.mem_web_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_wmask_o[b]) sram[bus.mem_addr_o][8*b +: 8] <= bus.mem_din_o[8*b +: 8];
      end else begin
        bus.mem_dout_i <= sram[bus.mem_addr_o];
      end
    end
  end

  // Reference model: flat byte memory addressed by byte address.
  logic [7:0] ref_mem [0:(4<<AW)-1];

  function automatic int size_bytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic void ref_access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                     input logic uns, input logic [31:0] wdata,
                                     output logic [31:0] rdata, output logic err,
                                     output logic [10:0] base);
    int n;
    logic [10:0] a;
    n     = size_bytes(size);
    a     = addr[10:0];
    err   = 1'b0;
    rdata = '0;
`ifdef MEM_BRIDGE_MISALIGN_ERR_EN
    if ((a % n) != 0) err = 1'b1;
`endif
    base = a - 11'(a % n);
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[base + 11'(i)] = wdata[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) rdata[8*i +: 8] = ref_mem[base + 11'(i)];
        if (!uns && n < 4 && rdata[8*n-1])
          for (int i = n; i < 4; i++) rdata[8*i +: 8] = 8'hFF;
      end
    end
  endfunction

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          exp_cyc;
    bit          lit_en;
    logic [31:0] lit;
    bit          seen;
  } rsp_t;

  rsp_t sb[$];

  bit          lit_pending = 0;
  logic [31:0] lit_val;
  bit          port_lit_en = 0;
  logic [3:0]  port_lit_wmask;
  logic [31:0] port_lit_din;
  logic [8:0]  port_lit_addr;

  // Accept monitor: evaluates the model and checks the SRAM drive for each accepted request.
  always @(negedge clk) begin : acc_mon
    rsp_t        e;
    logic [31:0] rd;
    logic        er;
    logic [10:0] base;
    logic [3:0]  exp_mask;
    logic [31:0] exp_din;
    int          n;
    if (reset_i) begin
      if (bus.req_valid_i && bus.req_ready_o) begin
        ref_access(bus.req_we_i, bus.req_addr_i, bus.req_size_i, bus.req_unsigned_i,
                   bus.req_wdata_i, rd, er, base);
        e.rdata   = rd;
        e.err     = er;
        e.exp_cyc = cyc + ((bus.req_we_i || er) ? 1 : 2);
        e.lit_en  = lit_pending;
        e.lit     = lit_val;
        e.seen    = 0;
        sb.push_back(e);
        lit_pending = 0;
        n = size_bytes(bus.req_size_i);
        check("mem_csb", 32'(bus.mem_csb_o), 32'(er));
        if (!er) begin
          check("mem_web", 32'(bus.mem_web_o), 32'(!bus.req_we_i));
          check("mem_addr", 32'(bus.mem_addr_o), 32'(base[10:2]));
          if (bus.req_we_i) begin
            exp_mask = (n == 1) ? 4'b0001 : (n == 2) ? 4'b0011 : 4'b1111;
            exp_mask = exp_mask << base[1:0];
            exp_din  = (n == 1) ? {4{bus.req_wdata_i[7:0]}}
                     : (n == 2) ? {2{bus.req_wdata_i[15:0]}} : bus.req_wdata_i;
            check("mem_wmask", 32'(bus.mem_wmask_o), 32'(exp_mask));
            check("mem_din", bus.mem_din_o, exp_din);
          end else begin
            check("mem_wmask_load", 32'(bus.mem_wmask_o), 32'd0);
          end
        end else begin
          check("mem_wmask_skip", 32'(bus.mem_wmask_o), 32'd0);
        end
        if (port_lit_en) begin
          check("lit_wmask", 32'(bus.mem_wmask_o), 32'(port_lit_wmask));
          check("lit_din", bus.mem_din_o, port_lit_din);
          check("lit_addr", 32'(bus.mem_addr_o), 32'(port_lit_addr));
          port_lit_en = 0;
        end
      end else begin
        check("idle_csb", 32'(bus.mem_csb_o), 32'd1);
        check("idle_wmask", 32'(bus.mem_wmask_o), 32'd0);
      end
    end
  end

  // Response monitor: compares presented responses with the scoreboard head.
  always @(negedge clk) begin : rsp_mon
    rsp_t e;
    if (reset_i) begin
      if (bus.rsp_valid_o) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected_valid", 32'(bus.rsp_valid_o), 32'd0);
        end else begin
          e = sb[0];
          if (!e.seen) begin
            check("rsp_latency", 32'(cyc), 32'(e.exp_cyc));
            e.seen = 1;
            sb[0] = e;
          end
          check("rsp_rdata", bus.rsp_rdata_o, e.rdata);
          check("rsp_err", 32'(bus.rsp_err_o), 32'(e.err));
          if (e.lit_en) check("rsp_rdata_lit", bus.rsp_rdata_o, e.lit);
          check("req_ready_in_resp", 32'(bus.req_ready_o), 32'(bus.rsp_ready_i));
          if (bus.rsp_ready_i) void'(sb.pop_front());
        end
      end else if (sb.size() > 0 && !sb[0].seen && cyc > sb[0].exp_cyc) begin
        check("rsp_missing", 32'(bus.rsp_valid_o), 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  // rsp_ready policy: 0 random, 1 always ready, 2 held low.
  int rdy_mode = 1;
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
      1:       bus.rsp_ready_i = 1'b1;
      default: bus.rsp_ready_i = 1'b0;
    endcase
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata);
    bit done = 0;
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = we;
    bus.req_addr_i     = addr;
    bus.req_size_i     = size;
    bus.req_unsigned_i = uns;
    bus.req_wdata_i    = wdata;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      done = bus.req_ready_o;
      @(posedge clk);
      #1;
    end
    bus.req_valid_i = 1'b0;
    if (!done) check("req_accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("wait_idle_drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic expect_lit(input logic [31:0] v);
    lit_pending = 1;
    lit_val     = v;
  endtask

  task automatic expect_port(input logic [3:0] m, input logic [31:0] d, input logic [8:0] a);
    port_lit_en    = 1;
    port_lit_wmask = m;
    port_lit_din   = d;
    port_lit_addr  = a;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    logic [31:0] a;
    bit          got;
    bus.req_valid_i    = 1'b0;
    bus.req_we_i       = 1'b0;
    bus.req_addr_i     = '0;
    bus.req_size_i     = '0;
    bus.req_unsigned_i = 1'b0;
    bus.req_wdata_i    = '0;
    bus.rsp_ready_i    = 1'b0;
    bus.mem_dout_i     = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      w = $urandom;
      sram[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[i*4 + b] = w[8*b +: 8];
    end

    // Reset: outputs idle, ready low and SRAM deselected even with a request present.
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b1;
    @(negedge clk);
    check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata_o, 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err_o), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready_o), 32'd0);
    check("rst_csb", 32'(bus.mem_csb_o), 32'd1);
    bus.req_valid_i = 1'b0;
    reset_i = 1'b1;
    @(posedge clk);
    #1;

    // Word store then load.
    expect_port(4'b1111, 32'hDEADBEEF, 9'd4);
    do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
    wait_idle();
    expect_lit(32'hDEADBEEF);
    do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    wait_idle();

    // Byte store at lane 3, signed and unsigned loads.
    expect_port(4'b1000, 32'h80808080, 9'd4);
    do_req(1'b1, 32'h13, 2'b00, 1'b0, 32'h00000080);
    wait_idle();
    expect_lit(32'hFFFFFF80);
    do_req(1'b0, 32'h13, 2'b00, 1'b0, 32'h0);
    wait_idle();
    expect_lit(32'h00000080);
    do_req(1'b0, 32'h13, 2'b00, 1'b1, 32'h0);
    wait_idle();

    // Half store on the upper half, half and word reads back.
    expect_port(4'b1100, 32'h12341234, 9'd8);
    do_req(1'b1, 32'h22, 2'b01, 1'b0, 32'h00001234);
    wait_idle();
    expect_lit(32'h00001234);
    do_req(1'b0, 32'h22, 2'b01, 1'b0, 32'h0);
    wait_idle();
    do_req(1'b0, 32'h20, 2'b10, 1'b0, 32'h0);
    wait_idle();

    // Response held under backpressure, then retired with a same-edge new request.
    rdy_mode = 2;
    do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      got = bus.rsp_valid_o;
    end
    check("hold_rsp_seen", 32'(got), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.rsp_valid_o), 32'd1);
      check("hold_req_ready", 32'(bus.req_ready_o), 32'd0);
    end
    @(posedge clk);
    #1;
    rdy_mode           = 1;
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = 1'b1;
    bus.req_addr_i     = 32'h40;
    bus.req_size_i     = 2'b10;
    bus.req_unsigned_i = 1'b0;
    bus.req_wdata_i    = 32'hCAFEF00D;
    @(negedge clk);
    check("b2b_accept", 32'(bus.req_ready_o), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    wait_idle();

    // Reset while the read is in flight: response discarded.
    do_req(1'b0, 32'h40, 2'b10, 1'b0, 32'h0);
    reset_i = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("midrst_req_ready", 32'(bus.req_ready_o), 32'd0);
    check("midrst_csb", 32'(bus.mem_csb_o), 32'd1);
    sb.delete();
    repeat (2) @(negedge clk);
    reset_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    expect_lit(32'hCAFEF00D);
    do_req(1'b0, 32'h40, 2'b10, 1'b0, 32'h0);
    wait_idle();

    // Misaligned half load.
    do_req(1'b1, 32'h00, 2'b10, 1'b0, 32'h11228344);
    wait_idle();
`ifdef MEM_BRIDGE_MISALIGN_ERR_EN
    expect_lit(32'h00000000);
`else
    expect_lit(32'hFFFF8344);
`endif
    do_req(1'b0, 32'h01, 2'b01, 1'b0, 32'h0);
    wait_idle();

    // Randomized traffic with random backpressure.
    rdy_mode = 0;
    for (int t = 0; t < 400; t++) begin
      a = $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) a = $urandom;
      do_req(1'($urandom), a, 2'($urandom), 1'($urandom), $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_mode = 1;
    wait_idle();
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
